seq_det_ctrl: RTL and testbench
===============================

// Module: seq_det_ctrl
// PURPOSE
//  Sequencer for a serial pattern detector: takes parallel words over a valid/ready input,
//  clears the detector, shifts each word in MSB-first, counts det_hit pulses, and returns the per-word count.
//  Sits between a word source and one detector instance, and owns that detector's reset and serial input.
// PARAMETERS
//  WORD_W   8  bits per word; >=2
//  CNT_W    4  width of match counter
//  DET_LAT  2  cycles from a bit on det_seq_in to its det_hit response; >=1
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        word available
//  in_ready    out  1        controller can accept a word
//  in_word     in   WORD_W   word to scan, MSB shifted first
//  out_valid   out  1        result available
//  out_ready   in   1        consumer takes result
//  out_count   out  CNT_W    matches found in word
//  out_flag    out  1        out_count != 0
//  det_rst     out  1        detector reset, one-cycle pulse per word
//  det_seq_in  out  1        detector serial bit
//  det_hit     in   1        detector match output
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; out_count=0; out_flag=0; det_rst=1 while rst is high, then 0; det_seq_in=0; busy=0.
//  - Reset mid-operation (any state): abandon the word and its result; no out_valid pulse follows.
//  - All outputs are registered.
//  - FSM: IDLE -> CLEAR -> SHIFT -> DRAIN -> REPORT -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready in cycle T, latch in_word, clear the counter, go to CLEAR.
//  - CLEAR (T+1): det_rst=1, det_seq_in=0.
//  - SHIFT (T+2 .. T+1+WORD_W): det_seq_in = word[WORD_W-1-i] on the i-th SHIFT cycle.
//  - DRAIN (DET_LAT cycles): det_seq_in=0.
//  - Hit window: det_hit is sampled only on cycles T+2+DET_LAT .. T+1+DET_LAT+WORD_W, exactly WORD_W samples.
//    - Window cycles that fall in SHIFT still count.
//    - Hits outside the window, including those caused by DRAIN zeros, are ignored.
//  - Count: +1 per sampled det_hit=1.
//  - REPORT: out_valid=1 from cycle T+2+WORD_W+DET_LAT, with out_count/out_flag stable.
//    - out_valid holds until out_ready; the handshake cycle returns to IDLE.
//    - in_ready rises the cycle after the handshake, so there is a one-cycle bubble.
//  - in_ready=0 in every state except IDLE; in_word is ignored while busy.
//  - Word-to-word throughput: WORD_W+DET_LAT+3 cycles minimum.
//  - out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  SEQ_DET_CTRL_SAT_EN defined:
//    - Counter saturates at 2^CNT_W-1.
//    - Extra port out_ovf (out, 1) goes high in REPORT if any hit was dropped by saturation.
//    - out_ovf clears to 0 on reset and when a new word is accepted.
//  Not defined: counter wraps modulo 2^CNT_W; no out_ovf port.
// TESTING
//  Bench uses a behavioural "110" detector model with DET_LAT=2.
//  1. rst=1 for 3 cycles, then 0 -> in_ready=1, out_valid=0, det_rst=0, busy=0, out_count=0.
//  2. in_word=8'b11011000, out_ready=1 ->
//     - det_rst high at T+1;
//     - bits 1,1,0,1,1,0,0,0 at T+2..T+9;
//     - out_valid at T+12 with out_count=2, out_flag=1.
//  3. in_word=8'hFF -> out_count=0, out_flag=0.
//     Then 8'b01101101 back-to-back -> out_count=2, accepted no earlier than the cycle after the first handshake.
//  4. out_ready=0 for 10 cycles in REPORT -> out_valid and out_count held.
//     in_valid=1 meanwhile -> in_ready stays 0.
//     out_ready=1 -> IDLE next cycle.
//  5. WORD_W=16, CNT_W=2, in_word=16'b1101101101101101 (5 matches) ->
//     - with SEQ_DET_CTRL_SAT_EN: out_count=3, out_ovf=1;
//     - without it: out_count=1.
//  6. rst pulsed during the 4th SHIFT cycle ->
//     - next cycle IDLE, det_rst=1 during rst, det_seq_in=0;
//     - no out_valid;
//     - the next word 8'b11011000 still gives count 2.

Source files
------------

// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - word input / result output handshake bundle for seq_det_ctrl; out_ovf present with SEQ_DET_CTRL_SAT_EN
interface seq_det_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_flag;
`ifdef SEQ_DET_CTRL_SAT_EN
    logic              out_ovf;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_count, out_flag, out_ovf
    );
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_count, out_flag, out_ovf
    );
`else
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_count, out_flag
    );
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_count, out_flag
    );
`endif
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - serial pattern detector sequencer; SEQ_DET_CTRL_SAT_EN selects saturating count plus out_ovf
// Clears the detector, shifts each word MSB-first, counts det_hit inside the latency-aligned window.
module seq_det_ctrl #(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq_det_ctrl_if.slave    bus,
    output logic             det_rst,
    output logic             det_seq_in,
    input  logic             det_hit,
    output logic             busy
);
    // tick counts cycles since the accept cycle: CLEAR is tick 1, the last DRAIN cycle is WIN_LAST
    localparam int TICK_LAST = WORD_W + DET_LAT + 1;
    localparam int TW        = $clog2(TICK_LAST + 2);
    localparam logic [TW-1:0] SHIFT_LAST = TW'(WORD_W + 1);
    localparam logic [TW-1:0] WIN_FIRST  = TW'(DET_LAT + 2);
    localparam logic [TW-1:0] WIN_LAST   = TW'(TICK_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              flag_q, flag_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              det_rst_q, det_rst_d;
    logic              det_seq_in_q, det_seq_in_d;
    logic              busy_q, busy_d;
`ifdef SEQ_DET_CTRL_SAT_EN
    logic              ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            word_q       <= '0;
            count_q      <= '0;
            flag_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            det_rst_q    <= 1'b1;
            det_seq_in_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SEQ_DET_CTRL_SAT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            word_q       <= word_d;
            count_q      <= count_d;
            flag_q       <= flag_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            det_rst_q    <= det_rst_d;
            det_seq_in_q <= det_seq_in_d;
            busy_q       <= busy_d;
`ifdef SEQ_DET_CTRL_SAT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        word_d       = word_q;
        count_d      = count_q;
        det_seq_in_d = 1'b0;
`ifdef SEQ_DET_CTRL_SAT_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_CLEAR;
                    tick_d  = TW'(1);
                    word_d  = bus.in_word;
                    count_d = '0;
`ifdef SEQ_DET_CTRL_SAT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                state_d      = S_SHIFT;
                tick_d       = tick_q + 1'b1;
                det_seq_in_d = word_q[WORD_W-1];
                word_d       = word_q << 1;
            end
            S_SHIFT: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == SHIFT_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    det_seq_in_d = word_q[WORD_W-1];
                    word_d       = word_q << 1;
                end
            end
            S_DRAIN: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == WIN_LAST) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // det_hit lags its bit by DET_LAT, so the window is the shift phase shifted by DET_LAT
        if ((state_q == S_SHIFT || state_q == S_DRAIN) &&
            tick_q >= WIN_FIRST && tick_q <= WIN_LAST && det_hit) begin
`ifdef SEQ_DET_CTRL_SAT_EN
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
`else
            count_d = count_q + 1'b1;
`endif
        end

        flag_d      = (count_d != '0);
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_REPORT);
        det_rst_d   = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = count_q;
    assign bus.out_flag  = flag_q;
`ifdef SEQ_DET_CTRL_SAT_EN
    assign bus.out_ovf   = ovf_q;
`endif
    assign det_rst       = det_rst_q;
    assign det_seq_in    = det_seq_in_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed bench for seq_det_ctrl with behavioural "110" detectors (DET_LAT=2)
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_det_ctrl_if #(.WORD_W(8),  .CNT_W(4)) bus_a ();
    seq_det_ctrl_if #(.WORD_W(16), .CNT_W(2)) bus_b ();
    logic det_rst_a, det_seq_in_a, det_hit_a, busy_a;
    logic det_rst_b, det_seq_in_b, det_hit_b, busy_b;

    seq_det_ctrl #(.WORD_W(8), .CNT_W(4), .DET_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .det_rst(det_rst_a), .det_seq_in(det_seq_in_a), .det_hit(det_hit_a), .busy(busy_a)
    );
    seq_det_ctrl #(.WORD_W(16), .CNT_W(2), .DET_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .det_rst(det_rst_b), .det_seq_in(det_seq_in_b), .det_hit(det_hit_b), .busy(busy_b)
    );

    // "110" detector: history register plus two pipeline stages gives two cycles of latency
    logic [2:0] hist_a = '0, hist_b = '0;
    logic hit1_a = 1'b0, hit2_a = 1'b0, hit1_b = 1'b0, hit2_b = 1'b0;
    always @(posedge clk) begin
        if (det_rst_a) begin
            hist_a <= '0; hit1_a <= 1'b0; hit2_a <= 1'b0;
        end else begin
            hist_a <= {hist_a[1:0], det_seq_in_a};
            hit1_a <= ({hist_a[1:0], det_seq_in_a} == 3'b110);
            hit2_a <= hit1_a;
        end
        if (det_rst_b) begin
            hist_b <= '0; hit1_b <= 1'b0; hit2_b <= 1'b0;
        end else begin
            hist_b <= {hist_b[1:0], det_seq_in_b};
            hit1_b <= ({hist_b[1:0], det_seq_in_b} == 3'b110);
            hit2_b <= hit1_b;
        end
    end
    assign det_hit_a = hit2_a;
    assign det_hit_b = hit2_b;

    // Caller is at a negedge; returns at the negedge after the result handshake
    task automatic run_word_a(input logic [7:0] w, output logic [3:0] cnt, output logic flg, output bit ok);
        int n;
        bus_a.in_valid = 1'b1; bus_a.in_word = w; bus_a.out_ready = 1'b1;
        n = 0;
        while (bus_a.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        bus_a.in_valid = 1'b0;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok  = (bus_a.out_valid === 1'b1);
        cnt = bus_a.out_count;
        flg = bus_a.out_flag;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_word = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_word = '0; bus_b.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (det_rst_a !== 1'b1) begin fails++; $display("FAIL reset_det_rst_high got %b want 1", det_rst_a); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus_a.in_ready); end
        tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus_a.out_valid); end
        tests++; if (det_rst_a !== 1'b0) begin fails++; $display("FAIL reset_det_rst_low got %b want 0", det_rst_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
        tests++; if (bus_a.out_count !== 4'd0 || bus_a.out_flag !== 1'b0) begin fails++; $display("FAIL reset_count got %0d/%b want 0/0", bus_a.out_count, bus_a.out_flag); end
        tests++; if (det_seq_in_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_seq_in_busy_b got %b/%b want 0/0", det_seq_in_a, busy_b); end
    endtask

    task automatic test_timing;
        logic [7:0] w;
        w = 8'b11011000;
        bus_a.in_valid = 1'b1; bus_a.in_word = w; bus_a.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_a.in_valid = 1'b0;
        tests++; if (det_rst_a !== 1'b1 || det_seq_in_a !== 1'b0) begin fails++; $display("FAIL clear_cycle det_rst/seq got %b/%b want 1/0", det_rst_a, det_seq_in_a); end
        tests++; if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL clear_busy_ready got %b/%b want 1/0", busy_a, bus_a.in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++; if (det_seq_in_a !== w[7-i] || det_rst_a !== 1'b0) begin fails++; $display("FAIL shift_bit%0d got %b want %b", i, det_seq_in_a, w[7-i]); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (bus_a.out_valid !== 1'b0 || det_seq_in_a !== 1'b0) begin fails++; $display("FAIL drain%0d valid/seq got %b/%b want 0/0", i, bus_a.out_valid, det_seq_in_a); end
        end
        @(negedge clk);
        tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL report_t12_valid got %b want 1", bus_a.out_valid); end
        tests++; if (bus_a.out_count !== 4'd2 || bus_a.out_flag !== 1'b1) begin fails++; $display("FAIL report_t12_count got %0d/%b want 2/1", bus_a.out_count, bus_a.out_flag); end
        @(negedge clk);
        tests++; if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL post_handshake valid/ready/busy got %b/%b/%b want 0/1/0", bus_a.out_valid, bus_a.in_ready, busy_a); end
    endtask

    task automatic test_back_to_back;
        int a0, a1, h, n;
        bus_a.in_valid = 1'b1; bus_a.in_word = 8'hFF; bus_a.out_ready = 1'b1;
        a0 = cyc;
        @(posedge clk); @(negedge clk);
        bus_a.in_word = 8'b01101101;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_first_timeout got %b want 1", bus_a.out_valid); end
        tests++; if (bus_a.out_count !== 4'd0 || bus_a.out_flag !== 1'b0) begin fails++; $display("FAIL b2b_ff_count got %0d/%b want 0/0", bus_a.out_count, bus_a.out_flag); end
        tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_in_report got %b want 0", bus_a.in_ready); end
        h = cyc;
        @(negedge clk);
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_hs got %b want 1", bus_a.in_ready); end
        a1 = cyc;
        tests++; if (a1 - a0 != 13 || a1 != h + 1) begin fails++; $display("FAIL b2b_period got %0d want 13", a1 - a0); end
        @(posedge clk); @(negedge clk);
        bus_a.in_valid = 1'b0;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 4'd2 || bus_a.out_flag !== 1'b1) begin fails++; $display("FAIL b2b_second_count got %b/%0d/%b want 1/2/1", bus_a.out_valid, bus_a.out_count, bus_a.out_flag); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_stall;
        int n;
        bus_a.in_valid = 1'b1; bus_a.in_word = 8'b11011000; bus_a.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus_a.in_word = 8'hAA;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 4'd2 || bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL stall%0d valid/count/ready got %b/%0d/%b want 1/2/0", i, bus_a.out_valid, bus_a.out_count, bus_a.in_ready); end
            @(negedge clk);
        end
        bus_a.out_ready = 1'b1; bus_a.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        tests++; if (busy_a !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL stall_release busy/ready/valid got %b/%b/%b want 0/1/0", busy_a, bus_a.in_ready, bus_a.out_valid); end
    endtask

    task automatic test_window_edges;
        logic [3:0] cnt; logic flg; bit ok;
        run_word_a(8'b00000011, cnt, flg, ok);
        tests++; if (!ok || cnt !== 4'd0 || flg !== 1'b0) begin fails++; $display("FAIL drain_hit_ignored got ok=%0d %0d/%b want 0/0", ok, cnt, flg); end
        run_word_a(8'b00000110, cnt, flg, ok);
        tests++; if (!ok || cnt !== 4'd1 || flg !== 1'b1) begin fails++; $display("FAIL last_window_hit got ok=%0d %0d/%b want 1/1", ok, cnt, flg); end
    endtask

    task automatic test_saturation;
        int n;
        bus_b.in_valid = 1'b1; bus_b.in_word = 16'b1101101101101101; bus_b.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_b.in_valid = 1'b0;
        n = 0;
        while (bus_b.out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
`ifdef SEQ_DET_CTRL_SAT_EN
        tests++; if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 2'd3 || bus_b.out_ovf !== 1'b1) begin fails++; $display("FAIL sat_count got %b/%0d/%b want 1/3/1", bus_b.out_valid, bus_b.out_count, bus_b.out_ovf); end
`else
        tests++; if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 2'd1) begin fails++; $display("FAIL wrap_count got %b/%0d want 1/1", bus_b.out_valid, bus_b.out_count); end
`endif
        @(posedge clk); @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_word = 16'h0000;
        @(posedge clk); @(negedge clk);
        bus_b.in_valid = 1'b0;
`ifdef SEQ_DET_CTRL_SAT_EN
        tests++; if (bus_b.out_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear_on_accept got %b want 0", bus_b.out_ovf); end
`endif
        n = 0;
        while (bus_b.out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        tests++; if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 2'd0) begin fails++; $display("FAIL zero_word_b got %b/%0d want 1/0", bus_b.out_valid, bus_b.out_count); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [3:0] cnt; logic flg; bit ok, seen;
        bus_a.in_valid = 1'b1; bus_a.in_word = 8'b11011000; bus_a.out_ready = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        tests++; if (busy_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_idle busy/ready got %b/%b want 0/1", busy_a, bus_a.in_ready); end
        tests++; if (det_rst_a !== 1'b1 || det_seq_in_a !== 1'b0) begin fails++; $display("FAIL midrst_det got %b/%b want 1/0", det_rst_a, det_seq_in_a); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_a.out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tests++; if (seen) begin fails++; $display("FAIL midrst_no_valid got 1 want 0"); end
        run_word_a(8'b11011000, cnt, flg, ok);
        tests++; if (!ok || cnt !== 4'd2 || flg !== 1'b1) begin fails++; $display("FAIL midrst_next_word got ok=%0d %0d/%b want 2/1", ok, cnt, flg); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_back_to_back();
        test_stall();
        test_window_edges();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
